// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, FSM encoding and ring-index helpers for lif_sched
//
// Contents:
//   W              default per-cell state width
//   lif_state_t    one cell's state word
//   sched_state_e  scheduler FSM encoding
//   idx_left       ring predecessor of a cell index (0 wraps to n-1)
//   idx_right      ring successor of a cell index (n-1 wraps to 0)
package lif_pkg;

  localparam int W = 4;

  typedef logic [W-1:0] lif_state_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMMIT  = 3'd3,
    S_DONE    = 3'd4
  } sched_state_e;

  function automatic int idx_left(input int i, input int n);
    return (i == 0) ? n - 1 : i - 1;
  endfunction

  function automatic int idx_right(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/lif_state_bank.sv
// rtl/lif_state_bank.sv - committed/shadow cell storage with load, capture, commit and ring reads
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load_en_i           write load_data_i into committed cell load_idx_i (already gated to IDLE)
//   load_idx_i          cell index for load; indices >= N_CELLS are dropped
//   load_data_i         value for load
//   cap_en_i            write cap_data_i into shadow cell rd_idx_i
//   cap_data_i          update-cell result
//   commit_i            copy every shadow cell into the committed array in one edge
//   rd_idx_i            current cell index for neighbour reads and capture
//   left_o/mid_o/right_o committed states of cells idx-1, idx, idx+1 (ring)
//   state_flat_o        committed states, cell i at [i*W +: W]
module lif_state_bank #(
  parameter  int N_CELLS = 4,
  parameter  int W       = 4,
  localparam int IW      = $clog2(N_CELLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en_i,
  input  logic [IW-1:0]        load_idx_i,
  input  logic [W-1:0]         load_data_i,
  input  logic                 cap_en_i,
  input  logic [W-1:0]         cap_data_i,
  input  logic                 commit_i,
  input  logic [IW-1:0]        rd_idx_i,
  output logic [W-1:0]         left_o,
  output logic [W-1:0]         mid_o,
  output logic [W-1:0]         right_o,
  output logic [N_CELLS*W-1:0] state_flat_o
);
  import lif_pkg::*;

  logic [W-1:0]  cur_q [N_CELLS];
  logic [W-1:0]  nxt_q [N_CELLS];
  logic [IW-1:0] left_idx;
  logic [IW-1:0] right_idx;

  assign left_idx  = IW'(idx_left(int'(rd_idx_i), N_CELLS));
  assign right_idx = IW'(idx_right(int'(rd_idx_i), N_CELLS));

  assign left_o  = cur_q[left_idx];
  assign mid_o   = cur_q[rd_idx_i];
  assign right_o = cur_q[right_idx];

  // Loads only happen in IDLE and commits only in COMMIT, so the two never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CELLS; i++) begin
        cur_q[i] <= '0;
        nxt_q[i] <= '0;
      end
    end else begin
      if (load_en_i && (int'(load_idx_i) < N_CELLS)) begin
        cur_q[load_idx_i] <= load_data_i;
      end
      if (commit_i) begin
        for (int i = 0; i < N_CELLS; i++) begin
          cur_q[i] <= nxt_q[i];
        end
      end
      if (cap_en_i) begin
        nxt_q[rd_idx_i] <= cap_data_i;
      end
    end
  end

  for (genvar g = 0; g < N_CELLS; g++) begin : g_flat
    assign state_flat_o[g*W +: W] = cur_q[g];
  end

endmodule

// File: rtl/lif_sched.sv
// rtl/lif_sched.sv - time-multiplexes one registered LIF update cell over a ring of cells
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load_en_i/load_idx_i/load_data_i  host load of a committed cell (IDLE only)
//   start_i               launch a run (IDLE only); samples gen_count_i and ext_in_i
//   gen_count_i           number of generations to run
//   ext_in_i              external stimulus, held in ext_q for the whole run
//   busy_o                high in every state but IDLE
//   done_o                one-cycle pulse at run completion
//   state_flat_o          committed cell states, cell i at [i*W +: W]
//   upd_in1_o..upd_in4_o  operands: left neighbour, self, right neighbour, ext
//   upd_out_i             update-cell result, valid the cycle after ISSUE
module lif_sched #(
  parameter  int N_CELLS = 4,
  parameter  int W       = 4,
  parameter  int GEN_W   = 8,
  localparam int IW      = $clog2(N_CELLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en_i,
  input  logic [IW-1:0]        load_idx_i,
  input  logic [W-1:0]         load_data_i,
  input  logic                 start_i,
  input  logic [GEN_W-1:0]     gen_count_i,
  input  logic [W-1:0]         ext_in_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N_CELLS*W-1:0] state_flat_o,
  output logic [W-1:0]         upd_in1_o,
  output logic [W-1:0]         upd_in2_o,
  output logic [W-1:0]         upd_in3_o,
  output logic [W-1:0]         upd_in4_o,
  input  logic [W-1:0]         upd_out_i
);
  import lif_pkg::*;

  sched_state_e   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [GEN_W-1:0] rem_q, rem_d;
  logic [W-1:0]   ext_q, ext_d;
  logic [W-1:0]   op1_q, op2_q, op3_q, op4_q;

  logic           load_ok, cap_en, commit, issue;
  logic [W-1:0]   rd_left, rd_mid, rd_right;
  logic           last_cell;

  assign last_cell = (idx_q == IW'(N_CELLS - 1));

  lif_state_bank #(
    .N_CELLS (N_CELLS),
    .W       (W)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (load_ok),
    .load_idx_i   (load_idx_i),
    .load_data_i  (load_data_i),
    .cap_en_i     (cap_en),
    .cap_data_i   (upd_out_i),
    .commit_i     (commit),
    .rd_idx_i     (idx_q),
    .left_o       (rd_left),
    .mid_o        (rd_mid),
    .right_o      (rd_right),
    .state_flat_o (state_flat_o)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = (gen_count_i == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_cell ? S_COMMIT : S_ISSUE;
      S_COMMIT:  state_d = (rem_q == GEN_W'(1)) ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    load_ok = (state_q == S_IDLE) && load_en_i;
    issue   = (state_q == S_ISSUE);
    cap_en  = (state_q == S_CAPTURE);
    commit  = (state_q == S_COMMIT);
  end

  // Counters and latched stimulus; COMMIT is only reached with rem >= 1, so no wrap.
  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    ext_d = ext_q;
    if ((state_q == S_IDLE) && start_i) begin
      rem_d = gen_count_i;
      ext_d = ext_in_i;
      idx_d = '0;
    end
    if (cap_en && !last_cell) idx_d = idx_q + 1'b1;
    if (commit) begin
      rem_d = rem_q - 1'b1;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      rem_q <= '0;
      ext_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      op3_q <= '0;
      op4_q <= '0;
    end else begin
      idx_q <= idx_d;
      rem_q <= rem_d;
      ext_q <= ext_d;
      if (issue) begin
        op1_q <= rd_left;
        op2_q <= rd_mid;
        op3_q <= rd_right;
        op4_q <= ext_q;
      end
    end
  end

  // Operands must be live during ISSUE so the registered cell answers in CAPTURE;
  // elsewhere they replay the last ISSUE values.
  assign upd_in1_o = issue ? rd_left  : op1_q;
  assign upd_in2_o = issue ? rd_mid   : op2_q;
  assign upd_in3_o = issue ? rd_right : op3_q;
  assign upd_in4_o = issue ? ext_q    : op4_q;

endmodule

// File: tb/tb_lif_sched.sv
// tb/tb_lif_sched.sv - directed self-checking bench for lif_sched with a behavioural update cell
module tb_lif_sched;

  logic        clk;
  logic        rst_n;
  logic        load_en_i;
  logic [1:0]  load_idx_i;
  logic [3:0]  load_data_i;
  logic        start_i;
  logic [7:0]  gen_count_i;
  logic [3:0]  ext_in_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] state_flat_o;
  logic [3:0]  upd_in1_o, upd_in2_o, upd_in3_o, upd_in4_o;
  logic [3:0]  upd_out;
  logic        mode_ext;

  int n_checks = 0;
  int n_pass   = 0;

  lif_sched #(.N_CELLS(4), .W(4), .GEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (load_en_i),
    .load_idx_i   (load_idx_i),
    .load_data_i  (load_data_i),
    .start_i      (start_i),
    .gen_count_i  (gen_count_i),
    .ext_in_i     (ext_in_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .state_flat_o (state_flat_o),
    .upd_in1_o    (upd_in1_o),
    .upd_in2_o    (upd_in2_o),
    .upd_in3_o    (upd_in3_o),
    .upd_in4_o    (upd_in4_o),
    .upd_out_i    (upd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered update cell: shift model passes the left neighbour, ext model passes ext.
  always @(posedge clk) begin
    if (!rst_n) upd_out <= 4'h0;
    else        upd_out <= mode_ext ? upd_in4_o : upd_in1_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic load4(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3);
    logic [3:0] v [4];
    v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
    for (int i = 0; i < 4; i++) begin
      load_en_i = 1'b1; load_idx_i = 2'(i); load_data_i = v[i];
      tick();
    end
    load_en_i = 1'b0;
  endtask

  // Starts a run in the current (IDLE) cycle 0 and steps to cycle exp_done+1.
  // inj_cyc>0 fires a load(cell0=0xE)+start+ext=0x5 burst in that mid-run cycle.
  task automatic launch(input string tag, input logic [7:0] g, input logic [3:0] ext,
                        input logic ld, input logic [1:0] ld_idx, input logic [3:0] ld_data,
                        input int inj_cyc, input int exp_done, input logic [15:0] exp_flat,
                        input logic chk_ops);
    int done_cyc, done_cnt;
    logic busy_bad, flat_bad, ops_moved;
    logic [15:0] prev_flat;
    logic [15:0] ops0;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; flat_bad = 0; ops_moved = 0;
    prev_flat = state_flat_o;
    ops0 = {upd_in1_o, upd_in2_o, upd_in3_o, upd_in4_o};
    start_i = 1'b1; gen_count_i = g; ext_in_i = ext;
    load_en_i = ld; load_idx_i = ld_idx; load_data_i = ld_data;
    for (int c = 1; c <= exp_done + 1; c++) begin
      tick();
      start_i = 1'b0; load_en_i = 1'b0;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy_o !== (c <= exp_done)) busy_bad = 1'b1;
      // committed state may only move at cycle 1 (IDLE load) or just after a COMMIT edge
      if (state_flat_o !== prev_flat && c > 1 && ((c - 1) % 9) != 0) flat_bad = 1'b1;
      prev_flat = state_flat_o;
      if ({upd_in1_o, upd_in2_o, upd_in3_o, upd_in4_o} !== ops0) ops_moved = 1'b1;
      if (c == inj_cyc) begin
        load_en_i = 1'b1; load_idx_i = 2'd0; load_data_i = 4'hE;
        start_i = 1'b1; ext_in_i = 4'h5;
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    chk({tag, "_flat_stable"}, 32'(flat_bad), 32'd0);
    chk({tag, "_state"}, 32'(state_flat_o), 32'(exp_flat));
    if (chk_ops) chk({tag, "_no_issue"}, 32'(ops_moved), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load_en_i = 1'b0; load_idx_i = '0; load_data_i = '0;
    start_i = 1'b0; gen_count_i = '0; ext_in_i = '0; mode_ext = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_state", 32'(state_flat_o), 32'h0);
    chk("reset_ops", 32'({upd_in1_o, upd_in2_o, upd_in3_o, upd_in4_o}), 32'h0);

    load4(4'h1, 4'h2, 4'h3, 4'h4);
    chk("load_state", 32'(state_flat_o), 32'h4321);

    // g=0: done in cycle 1, nothing touched, operands never leave their reset value
    launch("g0", 8'd0, 4'hA, 1'b0, 2'd0, 4'h0, 0, 1, 16'h4321, 1'b1);

    // g=1 shift, started in the IDLE cycle right after the previous busy
    launch("g1_shift", 8'd1, 4'h0, 1'b0, 2'd0, 4'h0, 0, 10, 16'h3214, 1'b0);

    load4(4'h1, 4'h2, 4'h3, 4'h4);
    launch("g4_shift", 8'd4, 4'h0, 1'b0, 2'd0, 4'h0, 0, 37, 16'h4321, 1'b0);

    // ext model: ext latched at start; the mid-run burst changes ext_in to 5 and must not matter
    mode_ext = 1'b1;
    launch("g2_ext", 8'd2, 4'hA, 1'b0, 2'd0, 4'h0, 5, 19, 16'hAAAA, 1'b0);
    mode_ext = 1'b0;

    // start + load(cell2=F) together, then mid-run load/start dropped: {1,2,F,4}->{4,1,2,F}->{F,4,1,2}
    load4(4'h1, 4'h2, 4'h3, 4'h4);
    launch("start_load", 8'd2, 4'h0, 1'b1, 2'd2, 4'hF, 4, 19, 16'h214F, 1'b0);

    // reset during CAPTURE of cell 2 in generation 1 (cycle 6)
    load4(4'h1, 4'h2, 4'h3, 4'h4);
    start_i = 1'b1; gen_count_i = 8'd2; ext_in_i = 4'h3;
    tick();
    start_i = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_state", 32'(state_flat_o), 32'h0);
    chk("midrst_ops", 32'({upd_in1_o, upd_in2_o, upd_in3_o, upd_in4_o}), 32'h0);
    rst_n = 1'b1;
    begin
      logic saw;
      saw = 1'b0;
      for (int c = 0; c < 25; c++) begin
        tick();
        if (done_o || busy_o) saw = 1'b1;
      end
      chk("midrst_quiet", 32'(saw), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
